// File: rtl/intra_pred_pkg.sv
// Shared definitions for the intra-prediction mode decider: mode numbering,
// decider FSM states and a width-limited saturating adder.
package intra_pred_pkg;

  typedef enum logic [3:0] {
    MODE_VERT = 4'd0,
    MODE_HOR  = 4'd1,
    MODE_DC   = 4'd2,
    MODE_DDL  = 4'd3,
    MODE_DDR  = 4'd4,
    MODE_VR   = 4'd5,
    MODE_HD   = 4'd6,
    MODE_VL   = 4'd7,
    MODE_HU   = 4'd8
  } mode_e;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_e;

  // Sum clamped to the largest value representable in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/intra_cost_cmp.sv
// Per-beat cost (SAD plus rate penalty, saturated) and the strict-less-than
// decision against the running minimum.
module intra_cost_cmp
  import intra_pred_pkg::*;
#(
  parameter int SAD_W  = 16,
  parameter int PEN_W  = 8,
  parameter int COST_W = SAD_W + 1
) (
  input  logic [SAD_W-1:0]  sad,
  input  logic [PEN_W-1:0]  penalty,
  input  logic              exempt,
  input  logic [COST_W-1:0] min_cost,
  input  logic              min_valid,
  output logic [COST_W-1:0] cost,
  output logic              take_new
);

  always_comb begin
    cost     = COST_W'(sat_add(64'(sad), exempt ? 64'd0 : 64'(penalty), COST_W));
    // Strict compare keeps the lower mode index on ties.
    take_new = !min_valid || (cost < min_cost);
  end

endmodule

// File: rtl/intra_mode_select_stream.sv
// Streaming intra mode decider: one SAD beat per mode in, {best mode, best cost}
// out. Handshakes: a beat/decision transfers on a rising edge where valid && ready.
module intra_mode_select_stream
  import intra_pred_pkg::*;
#(
  parameter  int NUM_MODES = 9,
  parameter  int SAD_W     = 16,
  parameter  int PEN_W     = 8,
  parameter  int PREF_MODE = int'(MODE_DC),
  localparam int MODE_W    = $clog2(NUM_MODES),
  localparam int COST_W    = SAD_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [PEN_W-1:0]  penalty,
  input  logic              sad_valid,
  output logic              sad_ready,
  input  logic [SAD_W-1:0]  sad_data,
  input  logic              sad_avail,
  output logic              best_valid,
  input  logic              best_ready,
  output logic [MODE_W-1:0] best_mode,
  output logic [COST_W-1:0] best_cost,
  output logic              best_none,
  output state_e            dbg_state
);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   cnt_q, cnt_d;
  logic [PEN_W-1:0]    pen_q, pen_d;
  logic [COST_W-1:0]   min_q, min_d;
  logic [MODE_W-1:0]   min_mode_q, min_mode_d;
  logic                any_q, any_d;
  logic                sad_ready_q, sad_ready_d;
  logic                best_valid_q, best_valid_d;
  logic [MODE_W-1:0]   best_mode_q, best_mode_d;
  logic [COST_W-1:0]   best_cost_q, best_cost_d;
  logic                best_none_q, best_none_d;

  logic                accept;
  logic                last_beat;
  logic [PEN_W-1:0]    pen_cur;
  logic [COST_W-1:0]   cost;
  logic                take_new;

  // A flush in the same cycle must not look like a completed handshake upstream.
  assign sad_ready  = sad_ready_q & ~flush;
  assign accept     = sad_valid & sad_ready;
  assign last_beat  = (cnt_q == MODE_W'(NUM_MODES - 1));
  assign pen_cur    = (cnt_q == '0) ? penalty : pen_q;
  assign best_valid = best_valid_q;
  assign best_mode  = best_mode_q;
  assign best_cost  = best_cost_q;
  assign best_none  = best_none_q;
  assign dbg_state  = state_q;

  intra_cost_cmp #(
    .SAD_W (SAD_W),
    .PEN_W (PEN_W),
    .COST_W(COST_W)
  ) u_cmp (
    .sad      (sad_data),
    .penalty  (pen_cur),
    .exempt   (cnt_q == MODE_W'(PREF_MODE)),
    .min_cost (min_q),
    .min_valid(any_q),
    .cost     (cost),
    .take_new (take_new)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pen_d        = pen_q;
    min_d        = min_q;
    min_mode_d   = min_mode_q;
    any_d        = any_q;
    sad_ready_d  = sad_ready_q;
    best_valid_d = best_valid_q;
    best_mode_d  = best_mode_q;
    best_cost_d  = best_cost_q;
    best_none_d  = best_none_q;
    if (flush) begin
      state_d      = ACCUM;
      cnt_d        = '0;
      min_d        = '0;
      min_mode_d   = MODE_W'(PREF_MODE);
      any_d        = 1'b0;
      sad_ready_d  = 1'b1;
      best_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          sad_ready_d = 1'b1;
          if (accept) begin
            if (cnt_q == '0) pen_d = penalty;
            if (sad_avail && take_new) begin
              min_d      = cost;
              min_mode_d = cnt_q;
            end
            any_d = any_q | sad_avail;
            if (last_beat) begin
              state_d      = OUTPUT;
              cnt_d        = '0;
              sad_ready_d  = 1'b0;
              best_valid_d = 1'b1;
              best_none_d  = !any_d;
              best_mode_d  = any_d ? min_mode_d : MODE_W'(PREF_MODE);
              best_cost_d  = any_d ? min_d : '1;
              min_d        = '0;
              min_mode_d   = MODE_W'(PREF_MODE);
              any_d        = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        OUTPUT: begin
          sad_ready_d = 1'b0;
          if (best_ready) begin
            state_d      = ACCUM;
            best_valid_d = 1'b0;
            sad_ready_d  = 1'b1;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      pen_q        <= '0;
      min_q        <= '0;
      min_mode_q   <= MODE_W'(PREF_MODE);
      any_q        <= 1'b0;
      sad_ready_q  <= 1'b0;
      best_valid_q <= 1'b0;
      best_mode_q  <= MODE_W'(PREF_MODE);
      best_cost_q  <= '0;
      best_none_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pen_q        <= pen_d;
      min_q        <= min_d;
      min_mode_q   <= min_mode_d;
      any_q        <= any_d;
      sad_ready_q  <= sad_ready_d;
      best_valid_q <= best_valid_d;
      best_mode_q  <= best_mode_d;
      best_cost_q  <= best_cost_d;
      best_none_q  <= best_none_d;
    end
  end

endmodule

// File: tb/tb_intra_mode_select_stream.sv
// Directed bench for intra_mode_select_stream: a 9-mode and a 4-mode instance
// share the SAD data bus; each has its own valid and ready.
module tb_intra_mode_select_stream;
  import intra_pred_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [7:0]  penalty;
  logic [15:0] sad_data;
  logic        sad_avail;

  logic        sad_valid9, sad_ready9, best_valid9, best_ready9, best_none9;
  logic [3:0]  best_mode9;
  logic [16:0] best_cost9;
  state_e      st9;

  logic        sad_valid4, sad_ready4, best_valid4, best_ready4, best_none4;
  logic [1:0]  best_mode4;
  logic [16:0] best_cost4;
  state_e      st4;

  logic [15:0] sads[9];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  intra_mode_select_stream #(.NUM_MODES(9)) u_dut9 (
    .clk(clk), .reset(reset), .flush(flush), .penalty(penalty),
    .sad_valid(sad_valid9), .sad_ready(sad_ready9), .sad_data(sad_data), .sad_avail(sad_avail),
    .best_valid(best_valid9), .best_ready(best_ready9), .best_mode(best_mode9),
    .best_cost(best_cost9), .best_none(best_none9), .dbg_state(st9)
  );

  intra_mode_select_stream #(.NUM_MODES(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(flush), .penalty(penalty),
    .sad_valid(sad_valid4), .sad_ready(sad_ready4), .sad_data(sad_data), .sad_avail(sad_avail),
    .best_valid(best_valid4), .best_ready(best_ready4), .best_mode(best_mode4),
    .best_cost(best_cost4), .best_none(best_none4), .dbg_state(st4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? sad_ready4 : sad_ready9;
  endfunction

  task automatic send_beat(input bit sel, input logic [15:0] d, input logic av);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    @(negedge clk);
    sad_data  = d;
    sad_avail = av;
    if (sel) sad_valid4 = 1'b1; else sad_valid9 = 1'b1;
    while (!got && n < 40) begin
      if (get_ready(sel)) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    sad_valid4 = 1'b0;
    sad_valid9 = 1'b0;
    check("beat_accepted", 32'(got), 32'd1);
  endtask

  // Sends the first n entries of sads[]; penalty changes to pen_after once beat 0 is in.
  task automatic send_block(input bit sel, input logic [7:0] pen, input logic [7:0] pen_after,
                            input logic [8:0] mask, input int n, input bit gaps);
    penalty = pen;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(sel, sads[k], mask[k]);
      if (k == 0) penalty = pen_after;
    end
  endtask

  task automatic expect_result(input string tag, input bit sel, input logic [3:0] m,
                               input logic [16:0] c, input logic none);
    check({tag, "_valid"}, 32'(sel ? best_valid4 : best_valid9), 32'd1);
    check({tag, "_mode"},  32'(sel ? {2'b00, best_mode4} : best_mode9), 32'(m));
    check({tag, "_cost"},  32'(sel ? best_cost4 : best_cost9), 32'(c));
    check({tag, "_none"},  32'(sel ? best_none4 : best_none9), 32'(none));
    @(negedge clk);
    if (sel) best_ready4 = 1'b1; else best_ready9 = 1'b1;
    @(posedge clk);
    #1;
    best_ready4 = 1'b0;
    best_ready9 = 1'b0;
    check({tag, "_valid_drop"}, 32'(sel ? best_valid4 : best_valid9), 32'd0);
    check({tag, "_ready_back"}, 32'(get_ready(sel)), 32'd1);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; penalty = '0; sad_data = '0; sad_avail = 1'b0;
    sad_valid9 = 1'b0; best_ready9 = 1'b0; sad_valid4 = 1'b0; best_ready4 = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_sad_ready", 32'(sad_ready9), 32'd0);
    check("rst_best_valid", 32'(best_valid9), 32'd0);
    check("rst_best_mode", 32'(best_mode9), 32'd2);
    check("rst_best_cost", 32'(best_cost9), 32'd0);
    check("rst_best_none", 32'(best_none9), 32'd0);
    check("rst_state", 32'(st9), 32'(ACCUM));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(sad_ready9), 32'd1);

    // Zero penalty, plain minimum
    sads = '{16'd50, 16'd40, 16'd60, 16'd40, 16'd70, 16'd80, 16'd90, 16'd99, 16'd45};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 9, 1'b0);
    expect_result("t1", 1'b0, 4'd1, 17'd40, 1'b0);

    // DC exempt from penalty: 58 beats 55+10
    sads = '{16'd55, 16'd60, 16'd58, 16'd70, 16'd70, 16'd75, 16'd80, 16'd90, 16'd70};
    send_block(1'b0, 8'd10, 8'd10, 9'h1FF, 9, 1'b0);
    expect_result("t2", 1'b0, 4'd2, 17'd58, 1'b0);

    // Only DC available
    sads = '{16'd0, 16'd0, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_block(1'b0, 8'd10, 8'd10, 9'b000000100, 9, 1'b0);
    expect_result("t3a", 1'b0, 4'd2, 17'd300, 1'b0);

    // Nothing available
    send_block(1'b0, 8'd10, 8'd10, 9'b000000000, 9, 1'b0);
    expect_result("t3b", 1'b0, 4'd2, 17'h1FFFF, 1'b1);

    // Widest sum on mode 0 must not wrap
    sads = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    send_block(1'b0, 8'd255, 8'd255, 9'b000000001, 9, 1'b0);
    expect_result("t4", 1'b0, 4'd0, 17'h100FE, 1'b0);

    // Consumer stalls for 5 cycles with a new beat already offered
    sads = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 9, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sad_valid9 = 1'b1;
      sad_data   = 16'd0;
      sad_avail  = 1'b1;
      #1;
      check("hold_valid", 32'(best_valid9), 32'd1);
      check("hold_mode", 32'(best_mode9), 32'd8);
      check("hold_cost", 32'(best_cost9), 32'd1);
      check("hold_sad_ready", 32'(sad_ready9), 32'd0);
      check("hold_state", 32'(st9), 32'(OUTPUT));
    end
    sad_valid9 = 1'b0;
    expect_result("t5a", 1'b0, 4'd8, 17'd1, 1'b0);

    // Back-to-back with random gaps; ties keep the lower index
    sads = '{16'd30, 16'd20, 16'd25, 16'd20, 16'd40, 16'd40, 16'd40, 16'd40, 16'd40};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 9, 1'b1);
    expect_result("t5b", 1'b0, 4'd1, 17'd20, 1'b0);

    // Penalty is latched on beat 0 even though the input drops to 0 afterwards
    sads = '{16'd100, 16'd95, 16'd200, 16'd200, 16'd200, 16'd200, 16'd200, 16'd200, 16'd200};
    send_block(1'b0, 8'd10, 8'd0, 9'h1FF, 9, 1'b1);
    expect_result("t5c", 1'b0, 4'd1, 17'd105, 1'b0);

    // Flush after 4 beats of tiny SADs
    sads = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 4, 1'b0);
    @(negedge clk);
    flush      = 1'b1;
    sad_valid9 = 1'b1;
    #1;
    check("flush_blocks_ready", 32'(sad_ready9), 32'd0);
    @(posedge clk);
    #1;
    flush      = 1'b0;
    sad_valid9 = 1'b0;
    check("flush_no_valid", 32'(best_valid9), 32'd0);
    check("flush_state", 32'(st9), 32'(ACCUM));
    sads = '{16'd100, 16'd90, 16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30, 16'd35};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 9, 1'b1);
    expect_result("t6a", 1'b0, 4'd7, 17'd30, 1'b0);

    // Reset pulse after 6 beats
    sads = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    send_block(1'b0, 8'd0, 8'd0, 9'h1FF, 6, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_sad_ready", 32'(sad_ready9), 32'd0);
    check("midrst_best_valid", 32'(best_valid9), 32'd0);
    check("midrst_best_cost", 32'(best_cost9), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sads = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10};
    send_block(1'b0, 8'd3, 8'd3, 9'h1FF, 9, 1'b1);
    expect_result("t6b", 1'b0, 4'd2, 17'd10, 1'b0);

    // Four-mode build
    sads = '{16'd50, 16'd40, 16'd60, 16'd40, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_block(1'b1, 8'd0, 8'd0, 9'h00F, 4, 1'b0);
    expect_result("m4_t1", 1'b1, 4'd1, 17'd40, 1'b0);
    sads = '{16'd0, 16'd0, 16'd300, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_block(1'b1, 8'd10, 8'd10, 9'b000000100, 4, 1'b0);
    expect_result("m4_t3a", 1'b1, 4'd2, 17'd300, 1'b0);
    send_block(1'b1, 8'd10, 8'd10, 9'b000000000, 4, 1'b0);
    expect_result("m4_t3b", 1'b1, 4'd2, 17'h1FFFF, 1'b1);
    check("m4_idle_9", 32'(best_valid9), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
